// File: rtl/clk_div_pkg.sv
// Shared encodings and default sizing for the clock-divider scheduler.
package clk_div_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DIVW = 16;
  localparam int DEF_LENW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_scheduler_rr_arbiter.sv
// Round-robin pick: searches upward from last_winner+1 with wrap, one-hot result.
module rr_arbiter
  import clk_div_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_winner) + i) % NREQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_scheduler.sv
// Shares one programmable clock divider among NREQ requesters, one burst of
// len ticks at a time; owner is picked round-robin.
module clk_div_scheduler
  import clk_div_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DIVW = DEF_DIVW,
  parameter int LENW = DEF_LENW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DIVW-1:0] cfg_div,
  input  logic [NREQ*LENW-1:0] cfg_len,
  output logic [NREQ-1:0]      gnt,
  output logic                 tick,
  output logic                 div_clk,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_winner;
  logic [DIVW-1:0]   div_q, count, div_sel;
  logic [LENW-1:0]   left_q, len_sel;
  logic [NREQ-1:0]   arb_grant, owner_oh;
  logic              arb_valid, req_own, tick_int;
  logic [IW-1:0]     win_idx;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req         (req),
    .last_winner (last_winner),
    .grant       (arb_grant),
    .valid       (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_grant[i]) win_idx = IW'(i);
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++)
      owner_oh[i] = (last_winner == IW'(i));
  end

  // Zero in either config field is treated as one.
  always_comb begin
    div_sel = cfg_div[int'(win_idx)*DIVW +: DIVW];
    len_sel = cfg_len[int'(win_idx)*LENW +: LENW];
    if (div_sel == '0) div_sel = DIVW'(1);
    if (len_sel == '0) len_sel = LENW'(1);
  end

  assign req_own  = |(req & owner_oh);
  assign tick_int = (state_q == ST_RUN) && req_own && (count == div_q - DIVW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_LOAD;
      ST_LOAD: state_d = req_own ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!req_own)                                state_d = ST_IDLE;
        else if (tick_int && left_q == LENW'(1))     state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt  = (state_q != ST_IDLE) ? owner_oh : '0;
    done = (state_q == ST_DONE) ? owner_oh : '0;
    busy = (state_q != ST_IDLE);
    tick = tick_int;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      left_q      <= '0;
      count       <= '0;
      div_clk     <= 1'b0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            div_q       <= div_sel;
            left_q      <= len_sel;
            last_winner <= win_idx;
          end
        end
        ST_LOAD: begin
          count   <= '0;
          div_clk <= 1'b0;
        end
        ST_RUN: begin
          if (!req_own) begin
            div_clk <= 1'b0;
          end else if (tick_int) begin
            count   <= '0;
            div_clk <= ~div_clk;
            left_q  <= left_q - LENW'(1);
          end else begin
            count <= count + DIVW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler; cycle c counts posedges after req is applied.
module tb_clk_div_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] cfg_div;
  logic [31:0] cfg_len;
  logic [3:0]  gnt, done;
  logic        tick, div_clk, busy;

  int tests = 0;
  int fails = 0;

  clk_div_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .cfg_div(cfg_div), .cfg_len(cfg_len),
    .gnt(gnt), .tick(tick), .div_clk(div_clk), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int i, input logic [15:0] d, input logic [7:0] l);
    cfg_div[i*16 +: 16] = d;
    cfg_len[i*8 +: 8]   = l;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; cfg_div = '0; cfg_len = '0;
    step(); step();
    tests++; if (gnt !== 4'b0)    begin fails++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    tests++; if (done !== 4'b0)   begin fails++; $display("FAIL reset_done got %b exp 0000", done); end
    tests++; if (tick !== 1'b0)   begin fails++; $display("FAIL reset_tick got %b exp 0", tick); end
    tests++; if (div_clk !== 1'b0) begin fails++; $display("FAIL reset_divclk got %b exp 0", div_clk); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    step();
  endtask

  // Requester 1, div=3, len=2: ticks at 4 and 7, done at 8, idle from 9.
  task automatic test_single();
    logic [3:0] eg, ed; logic et, ec;
    set_cfg(1, 16'd3, 8'd2);
    req = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      step();
      eg = (c <= 8) ? 4'b0010 : 4'b0000;
      et = (c == 4 || c == 7);
      ed = (c == 8) ? 4'b0010 : 4'b0000;
      ec = (c >= 5 && c <= 7);
      tests++; if (gnt !== eg)     begin fails++; $display("FAIL single_gnt c=%0d got %b exp %b", c, gnt, eg); end
      tests++; if (tick !== et)    begin fails++; $display("FAIL single_tick c=%0d got %b exp %b", c, tick, et); end
      tests++; if (done !== ed)    begin fails++; $display("FAIL single_done c=%0d got %b exp %b", c, done, ed); end
      tests++; if (div_clk !== ec) begin fails++; $display("FAIL single_divclk c=%0d got %b exp %b", c, div_clk, ec); end
      if (c == 8) req = 4'b0000;
    end
  endtask

  // All four held with div=1,len=1: each grant spans 3 cycles then one idle.
  task automatic test_round_robin();
    logic [3:0] eg;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_cfg(i, 16'd1, 8'd1);
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c % 4 == 0) eg = 4'b0000;
      else            eg = 4'b0001 << (((c - 1) / 4) % 4);
      tests++; if (gnt !== eg) begin fails++; $display("FAIL rr_gnt c=%0d got %b exp %b", c, gnt, eg); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_zero_cfg();
    int nt = 0;
    set_cfg(2, 16'd0, 8'd0);
    req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (tick === 1'b1) nt++;
      if (c == 2) begin
        tests++; if (tick !== 1'b1) begin fails++; $display("FAIL zero_tick c=2 got %b exp 1", tick); end
      end
      if (c == 3) begin
        tests++; if (done !== 4'b0100) begin fails++; $display("FAIL zero_done got %b exp 0100", done); end
        req = 4'b0000;
      end
      if (c == 4) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got %b exp 0", busy); end
      end
    end
    tests++; if (nt != 1) begin fails++; $display("FAIL zero_tickcount got %0d exp 1", nt); end
  endtask

  // Requester 3, div=4: first tick at 5, req dropped during cycle 7.
  task automatic test_abort();
    set_cfg(3, 16'd4, 8'd3);
    req = 4'b1000;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 5) begin
        tests++; if (tick !== 1'b1) begin fails++; $display("FAIL abort_first_tick got %b exp 1", tick); end
      end
      if (c == 7) begin
        tests++; if (div_clk !== 1'b1) begin fails++; $display("FAIL abort_divclk_pre got %b exp 1", div_clk); end
        req = 4'b0000;
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL abort_tick_c7 got %b exp 0", tick); end
      end
      if (c >= 8) begin
        tests++; if (tick !== 1'b0)    begin fails++; $display("FAIL abort_tick c=%0d got %b exp 0", c, tick); end
        tests++; if (done !== 4'b0)    begin fails++; $display("FAIL abort_done c=%0d got %b exp 0000", c, done); end
        tests++; if (div_clk !== 1'b0) begin fails++; $display("FAIL abort_divclk c=%0d got %b exp 0", c, div_clk); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL abort_busy c=%0d got %b exp 0", c, busy); end
      end
    end
  endtask

  // Requester 0, div=3 len=3; config rewritten after the first tick must not matter.
  task automatic test_cfg_change();
    logic et; logic [3:0] ed;
    set_cfg(0, 16'd3, 8'd3);
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      step();
      et = (c == 4 || c == 7 || c == 10);
      ed = (c == 11) ? 4'b0001 : 4'b0000;
      tests++; if (tick !== et) begin fails++; $display("FAIL cfgchg_tick c=%0d got %b exp %b", c, tick, et); end
      tests++; if (done !== ed) begin fails++; $display("FAIL cfgchg_done c=%0d got %b exp %b", c, done, ed); end
      if (c == 5) set_cfg(0, 16'd7, 8'd1);
      if (c == 11) req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid();
    logic et; logic [3:0] ed;
    set_cfg(1, 16'd2, 8'd4);
    req = 4'b0010;
    for (int c = 1; c <= 4; c++) step();
    tests++; if (div_clk !== 1'b1) begin fails++; $display("FAIL rstmid_divclk_pre got %b exp 1", div_clk); end
    reset = 1'b1; req = 4'b0000;
    step();
    tests++; if (gnt !== 4'b0)     begin fails++; $display("FAIL rstmid_gnt got %b exp 0000", gnt); end
    tests++; if (tick !== 1'b0)    begin fails++; $display("FAIL rstmid_tick got %b exp 0", tick); end
    tests++; if (div_clk !== 1'b0) begin fails++; $display("FAIL rstmid_divclk got %b exp 0", div_clk); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests++; if (done !== 4'b0)    begin fails++; $display("FAIL rstmid_done got %b exp 0000", done); end
    reset = 1'b0;
    step();
    set_cfg(2, 16'd1, 8'd2);
    req = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step();
      et = (c == 2 || c == 3);
      ed = (c == 4) ? 4'b0100 : 4'b0000;
      tests++; if (gnt !== ((c <= 4) ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL rstmid_regnt c=%0d got %b", c, gnt); end
      tests++; if (tick !== et) begin fails++; $display("FAIL rstmid_retick c=%0d got %b exp %b", c, tick, et); end
      tests++; if (done !== ed) begin fails++; $display("FAIL rstmid_redone c=%0d got %b exp %b", c, done, ed); end
      if (c == 4) req = 4'b0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_cfg();
    test_abort();
    test_cfg_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
